uart_tdr_fifo: RTL and testbench

//   Parametrised successor to the single-entry transmit data register (TDR): a CPU-mapped TX FIFO.

---
 rtl/uart_tdr_fifo.sv | 84 ++++++++
 tb/tb_uart_tdr_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_tdr_fifo.sv
// uart_tdr_fifo: CPU-mapped TX FIFO behind the legacy TDR address, show-ahead pop port to the transmitter.
// Define TDR_THR_IRQ_EN to add the TTHR register and the fill-threshold interrupt.
module uart_tdr_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 16,
  parameter logic [ADDR_W-1:0] TDR_ADDR = 'h00,
  parameter logic [ADDR_W-1:0] TSR_ADDR = 'h01,
  parameter logic [ADDR_W-1:0] TCNT_ADDR = 'h02,
  parameter logic [ADDR_W-1:0] TTHR_ADDR = 'h03
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              tx_pop,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              fifo_full,
  output logic              ovf_err,
  output logic              irq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, count_next, thr;
  logic [DATA_W-1:0] shadow, rdata_next;
  logic wr, rd, tdr_wr, tsr_wr, empty, pop, push, ovf, flush, clr;
  assign wr = cpu_cs && cpu_we;
  assign rd = cpu_cs && cpu_re;
  assign tdr_wr = wr && cpu_addr == TDR_ADDR;
  assign tsr_wr = wr && cpu_addr == TSR_ADDR;
  assign empty = count == '0;
  assign fifo_full = count == FULL_CNT;
  assign tx_valid = !empty;
  assign tx_data = mem[rd_ptr];
  assign pop = tx_pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push = tdr_wr && (!fifo_full || pop);
  assign ovf = tdr_wr && fifo_full && !pop;
  assign flush = tsr_wr && cpu_wdata[7];
  assign clr = tsr_wr && cpu_wdata[2];
  assign count_next = flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  assign rdata_next = (cpu_addr == TDR_ADDR)  ? shadow :
                      (cpu_addr == TSR_ADDR)  ? DATA_W'({ovf_err, fifo_full, empty}) :
                      (cpu_addr == TCNT_ADDR) ? DATA_W'(count) :
                      (cpu_addr == TTHR_ADDR) ? DATA_W'(thr) : '0;
  always_ff @(posedge clk)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      shadow <= '0;
      ovf_err <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      if (tdr_wr) shadow <= cpu_wdata;
      if (rd) cpu_rdata <= rdata_next;
      ovf_err <= ovf || (ovf_err && !clr);
      count <= count_next;
      rd_ptr <= flush ? '0 : rd_ptr + AW'(pop);
      wr_ptr <= flush ? '0 : wr_ptr + AW'(push);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= cpu_wdata;
`ifdef TDR_THR_IRQ_EN
  always_ff @(posedge clk)
    if (rst) begin
      thr <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && cpu_addr == TTHR_ADDR) thr <= cpu_wdata[AW:0];
      irq <= count_next <= thr;
    end
`else
  assign thr = '0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tdr_fifo.sv
// tb_uart_tdr_fifo: directed plus random stimulus against a queue-based model of the TX FIFO register map.
module tb_uart_tdr_fifo;
  logic clk = 0, rst = 0, cpu_cs = 0, cpu_we = 0, cpu_re = 0, tx_pop = 0;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0;
  logic [7:0] cpu_rdata, tx_data;
  logic tx_valid, fifo_full, ovf_err, irq;
  int total = 0, bad = 0;
  logic [7:0] mq[$];
  logic [7:0] m_shadow = 0, m_rdata = 0, last, wd;
  logic [4:0] m_thr = 0;
  logic m_ovf = 0, m_irq = 0;
  uart_tdr_fifo dut (
    .clk(clk), .rst(rst), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .tx_pop(tx_pop), .tx_data(tx_data), .tx_valid(tx_valid),
    .fifo_full(fifo_full), .ovf_err(ovf_err), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic cyc(input logic r, input logic we, input logic re, input logic [7:0] a,
                     input logic [7:0] d, input logic p);
    logic [4:0] old_thr;
    rst = r; cpu_cs = we | re; cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d; tx_pop = p;
    old_thr = m_thr;
    if (re) begin
      if (a == 0) m_rdata = m_shadow;
      else if (a == 1) m_rdata = {5'b0, m_ovf, mq.size() == 16, mq.size() == 0};
      else if (a == 2) m_rdata = 8'(mq.size());
      else if (a == 3) m_rdata = 8'(m_thr);
      else m_rdata = 0;
    end
    if (p && mq.size() > 0) void'(mq.pop_front());
    if (we && a == 0) begin
      m_shadow = d;
      if (mq.size() < 16) mq.push_back(d);
      else m_ovf = 1;
    end
    if (we && a == 1) begin
      if (d[2]) m_ovf = 0;
      if (d[7]) mq.delete();
    end
`ifdef TDR_THR_IRQ_EN
    if (we && a == 3) m_thr = d[4:0];
    m_irq = mq.size() <= int'(old_thr);
`endif
    if (r) begin
      mq.delete(); m_shadow = 0; m_rdata = 0; m_ovf = 0; m_thr = 0; m_irq = 0;
    end
    @(posedge clk); #1;
    rst = 0; cpu_cs = 0; cpu_we = 0; cpu_re = 0; tx_pop = 0;
    chk("tx_valid", tx_valid, mq.size() > 0);
    chk("fifo_full", fifo_full, mq.size() == 16);
    chk("ovf_err", ovf_err, m_ovf);
    chk("cpu_rdata", cpu_rdata, m_rdata);
    chk("irq", irq, m_irq);
    if (mq.size() > 0) chk("tx_data", tx_data, mq[0]);
  endtask
  initial begin
    #1;
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_full", fifo_full, 0);
    // write/read-back of TDR while the transmitter drains
    for (int i = 0; i < 100; i++) begin
      wd = 8'($urandom);
      cyc(0, 1, 0, 0, wd, 1);
      cyc(0, 0, 1, 0, 0, 1);
      chk("tdr_rb", cpu_rdata, wd);
      chk("tdr_rb_ovf", ovf_err, 0);
    end
    cyc(0, 1, 0, 1, 8'h80, 0);
    for (int i = 1; i <= 17; i++) cyc(0, 1, 0, 0, 8'(i), 0);
    cyc(0, 0, 1, 2, 0, 0);
    chk("tcnt16", cpu_rdata, 16);
    chk("full16", fifo_full, 1);
    cyc(0, 0, 1, 1, 0, 0);
    chk("tsr06", cpu_rdata, 8'h06);
    cyc(0, 0, 1, 0, 0, 0);
    chk("tdr11", cpu_rdata, 8'h11);
    for (int i = 1; i <= 16; i++) begin
      chk("pop_order", tx_data, 8'(i));
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("drained", tx_valid, 0);
    // push and pop together while full: accepted, no new overflow
    cyc(0, 1, 0, 1, 8'h04, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 8'(8'h20 + i), 0);
    cyc(0, 1, 0, 0, 8'hAA, 1);
    chk("full_pp_ovf", ovf_err, 0);
    cyc(0, 0, 1, 2, 0, 0);
    chk("full_pp_cnt", cpu_rdata, 16);
    for (int i = 0; i < 16; i++) begin
      last = tx_data;
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("last_aa", last, 8'hAA);
    cyc(0, 1, 0, 0, 8'h55, 1);
    chk("empty_pp", tx_data, 8'h55);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) cyc(0, 1, 0, 0, 8'(i), 0);
    chk("ovf_set", ovf_err, 1);
    cyc(0, 1, 0, 1, 8'h04, 0);
    chk("ovf_clr", ovf_err, 0);
    cyc(0, 1, 0, 1, 8'h80, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 8'(8'h30 + i), 0);
    cyc(0, 1, 0, 1, 8'h80, 1);
    chk("flush_valid", tx_valid, 0);
    cyc(0, 0, 1, 2, 0, 0);
    chk("flush_cnt", cpu_rdata, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("flush_shadow", cpu_rdata, 8'h34);
    cyc(0, 1, 1, 0, 8'h77, 0);
    chk("we_re_prewrite", cpu_rdata, 8'h34);
    cyc(0, 1, 0, 2, 8'h09, 0);
    cyc(0, 0, 1, 2, 0, 0);
    chk("tcnt_ro", cpu_rdata, 1);
    cyc(0, 1, 0, 3, 8'h05, 0);
    cyc(0, 0, 1, 3, 0, 0);
    cyc(0, 0, 1, 8'h40, 0, 0);
    chk("unmapped", cpu_rdata, 0);
    for (int i = 0; i < 400; i++) begin
      logic we, re, p;
      logic [7:0] a, d;
      we = ($urandom % 3) != 0;
      re = ($urandom % 3) == 0;
      p = ($urandom % 2) == 0;
      a = ($urandom % 5 == 0) ? 8'($urandom % 6) : 8'h00;
      d = 8'($urandom);
      if (a == 1 && ($urandom % 4) != 0) d[7] = 0;
      cyc(0, we, re, a, d, p);
    end
    cyc(0, 1, 0, 1, 8'h84, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8'(8'h60 + i), 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 2, 0, 0);
    chk("rst_cnt_rdata", cpu_rdata, 0);
    chk("rst_cnt_valid", tx_valid, 0);
    cyc(0, 0, 1, 2, 0, 0);
    chk("rst_tcnt", cpu_rdata, 0);
`ifdef TDR_THR_IRQ_EN
    chk("irq_after_rst", irq, 1);
    cyc(0, 1, 0, 3, 8'h02, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 8'(i), 0);
    chk("irq_above", irq, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("irq_pop1", irq, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("irq_pop2", irq, 1);
`else
    chk("irq_off", irq, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
